// File: rtl/varredura_display.sv
// Time-multiplexed driver for common-anode 7-segment digits: one shared hex
// decoder scanned round-robin, with a guard gap per slot and double-buffered values.

module display (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);
    // Active-low, gfedcba order
    always_comb begin
        case (i_hex)
            4'h0:    o_seg = 7'b1000000;
            4'h1:    o_seg = 7'b1111001;
            4'h2:    o_seg = 7'b0100100;
            4'h3:    o_seg = 7'b0110000;
            4'h4:    o_seg = 7'b0011001;
            4'h5:    o_seg = 7'b0010010;
            4'h6:    o_seg = 7'b0000010;
            4'h7:    o_seg = 7'b1111000;
            4'h8:    o_seg = 7'b0000000;
            4'h9:    o_seg = 7'b0011000;
            4'hA:    o_seg = 7'b0001000;
            4'hB:    o_seg = 7'b0000011;
            4'hC:    o_seg = 7'b1000110;
            4'hD:    o_seg = 7'b0100001;
            4'hE:    o_seg = 7'b0000110;
            default: o_seg = 7'b0001110;
        endcase
    end
endmodule

module varredura_display #(
    parameter int NUM_DIGITOS   = 4,
    parameter int DIV_VARREDURA = 50000,
    parameter int GUARDA        = 500
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [4*NUM_DIGITOS-1:0] valor,
    input  logic                     carregar,
    input  logic                     apagar_zeros,
    output logic [6:0]               segmentos,
    output logic [NUM_DIGITOS-1:0]   digito_en,
    output logic                     atualizado,
    output logic                     o_estado
);
    localparam int CONT_W = $clog2(DIV_VARREDURA);
    localparam int IDX_W  = $clog2(NUM_DIGITOS);
    localparam logic [CONT_W-1:0] C_FIM_GUARDA = CONT_W'(GUARDA - 1);
    localparam logic [CONT_W-1:0] C_FIM_SLOT   = CONT_W'(DIV_VARREDURA - 1);
    localparam logic [IDX_W-1:0]  C_IDX_ULT    = IDX_W'(NUM_DIGITOS - 1);

    typedef enum logic [0:0] {GUARDA_ST, MOSTRA} estado_t;

    estado_t                   r_estado;
    logic [CONT_W-1:0]         r_cont;
    logic [IDX_W-1:0]          r_indice;
    logic [4*NUM_DIGITOS-1:0]  r_sombra;
    logic [4*NUM_DIGITOS-1:0]  r_ativo;
    logic                      r_apaga_ativo;
    logic [6:0]                r_segmentos;
    logic [NUM_DIGITOS-1:0]    r_digito_en;
    logic                      r_atualizado;

    logic [3:0]                w_nibble;
    logic                      w_resto_zero;
    logic                      w_apaga;
    logic [6:0]                w_seg_dec;
    logic [6:0]                w_seg_lit;
    logic [NUM_DIGITOS-1:0]    w_en_lit;

    // Select the current nibble and check whether it and all higher nibbles are zero
    always_comb begin
        w_nibble     = 4'h0;
        w_resto_zero = 1'b1;
        w_en_lit     = '1;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (IDX_W'(i) == r_indice) begin
                w_nibble    = r_ativo[4*i +: 4];
                w_en_lit[i] = 1'b0;
            end
            if (IDX_W'(i) >= r_indice && r_ativo[4*i +: 4] != 4'h0)
                w_resto_zero = 1'b0;
        end
    end

    display u_display (
        .i_hex (w_nibble),
        .o_seg (w_seg_dec)
    );

    assign w_apaga   = r_apaga_ativo && (r_indice != '0) && w_resto_zero;
    assign w_seg_lit = w_apaga ? 7'b1111111 : w_seg_dec;

    // Outputs are loaded on the same edge as the state change, so they track the FSM exactly
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado      <= GUARDA_ST;
            r_cont        <= '0;
            r_indice      <= '0;
            r_sombra      <= '0;
            r_ativo       <= '0;
            r_apaga_ativo <= 1'b0;
            r_segmentos   <= 7'b1111111;
            r_digito_en   <= '1;
            r_atualizado  <= 1'b0;
        end else begin
            r_atualizado <= 1'b0;
            if (carregar)
                r_sombra <= valor;
            case (r_estado)
                GUARDA_ST: begin
                    r_cont <= r_cont + CONT_W'(1);
                    if (r_cont == C_FIM_GUARDA) begin
                        r_estado    <= MOSTRA;
                        r_segmentos <= w_seg_lit;
                        r_digito_en <= w_en_lit;
                    end
                end
                MOSTRA: begin
                    if (r_cont == C_FIM_SLOT) begin
                        r_cont      <= '0;
                        r_estado    <= GUARDA_ST;
                        r_segmentos <= 7'b1111111;
                        r_digito_en <= '1;
                        // Frame boundary: the only place the active copy changes
                        if (r_indice == C_IDX_ULT) begin
                            r_indice      <= '0;
                            r_ativo       <= r_sombra;
                            r_apaga_ativo <= apagar_zeros;
                            r_atualizado  <= (r_sombra != r_ativo);
                        end else begin
                            r_indice <= r_indice + IDX_W'(1);
                        end
                    end else begin
                        r_cont <= r_cont + CONT_W'(1);
                    end
                end
                default: r_estado <= GUARDA_ST;
            endcase
        end
    end

    assign segmentos  = r_segmentos;
    assign digito_en  = r_digito_en;
    assign atualizado = r_atualizado;
    assign o_estado   = (r_estado == MOSTRA);
endmodule

// File: tb/tb_varredura_display.sv
// Directed bench for varredura_display with NUM_DIGITOS=4, DIV_VARREDURA=8, GUARDA=2.

module tb_varredura_display;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] valor = 16'h0000;
    logic        carregar = 1'b0;
    logic        apagar_zeros = 1'b0;
    logic [6:0]  segmentos;
    logic [3:0]  digito_en;
    logic        atualizado;
    logic        o_estado;

    int checks = 0;
    int errors = 0;

    varredura_display #(
        .NUM_DIGITOS   (4),
        .DIV_VARREDURA (8),
        .GUARDA        (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .valor        (valor),
        .carregar     (carregar),
        .apagar_zeros (apagar_zeros),
        .segmentos    (segmentos),
        .digito_en    (digito_en),
        .atualizado   (atualizado),
        .o_estado     (o_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks one 32-cycle frame starting at its first guard cycle.
    // exp_segs = {d3,d2,d1,d0}; up to two loads can be issued at chosen cycles.
    task automatic check_frame(input string tag, input logic [27:0] exp_segs, input logic exp_upd,
                               input int ld_a_c, input logic [15:0] ld_a_v,
                               input int ld_b_c, input logic [15:0] ld_b_v);
        for (int c = 0; c < 32; c++) begin
            int slot;
            int pos;
            logic [3:0] en_exp;
            logic [6:0] seg_exp;
            slot = c / 8;
            pos  = c % 8;
            if (pos < 2) begin
                en_exp  = 4'hF;
                seg_exp = SB;
            end else begin
                en_exp  = ~(4'b0001 << slot);
                seg_exp = exp_segs[slot*7 +: 7];
            end
            chk({tag, "_en"}, {28'd0, digito_en}, {28'd0, en_exp});
            chk({tag, "_seg"}, {25'd0, segmentos}, {25'd0, seg_exp});
            chk({tag, "_upd"}, {31'd0, atualizado}, {31'd0, (c == 0) ? exp_upd : 1'b0});
            if (c == ld_a_c) begin
                carregar = 1'b1;
                valor    = ld_a_v;
            end else if (c == ld_b_c) begin
                carregar = 1'b1;
                valor    = ld_b_v;
            end
            tick();
            carregar = 1'b0;
        end
    endtask

    initial begin
        // Reset held for a few edges
        tick();
        tick();
        chk("rst_seg", {25'd0, segmentos}, {25'd0, SB});
        chk("rst_en", {28'd0, digito_en}, 32'h0000000F);
        chk("rst_upd", {31'd0, atualizado}, 32'd0);
        chk("rst_state", {31'd0, o_estado}, 32'd0);
        reset = 1'b0;

        // Idle frames 0 and 1: all digits show 0, no update pulse
        check_frame("idle0", {S0, S0, S0, S0}, 1'b0, -1, 16'h0, -1, 16'h0);
        check_frame("idle1", {S0, S0, S0, S0}, 1'b0, -1, 16'h0, -1, 16'h0);

        // Load A5F0 mid-frame; appears next frame with a pulse
        check_frame("ld_a5f0", {S0, S0, S0, S0}, 1'b0, 10, 16'hA5F0, -1, 16'h0);
        check_frame("show_a5f0", {SA, S5, SF, S0}, 1'b1, -1, 16'h0, -1, 16'h0);

        // Load 0007 with blanking enabled
        apagar_zeros = 1'b1;
        check_frame("ld_0007", {SA, S5, SF, S0}, 1'b0, 5, 16'h0007, -1, 16'h0);
        apagar_zeros = 1'b0;
        check_frame("blank_0007", {SB, SB, SB, S7}, 1'b1, -1, 16'h0, -1, 16'h0);

        // Same value without blanking: no pulse since value unchanged
        apagar_zeros = 1'b1;
        check_frame("noblank_0007", {S0, S0, S0, S7}, 1'b0, 3, 16'h0100, -1, 16'h0);

        // 0100 blanked: only the top digit goes dark, interior zeros kept
        check_frame("blank_0100", {SB, S1, S0, S0}, 1'b1, 12, 16'h1111, 31, 16'h2222);

        // Second load coincided with the boundary: 1111 first, then 2222
        check_frame("show_1111", {S1, S1, S1, S1}, 1'b1, -1, 16'h0, -1, 16'h0);
        check_frame("show_2222", {S2, S2, S2, S2}, 1'b0 | 1'b1, -1, 16'h0, -1, 16'h0);

        // Reset during digit 2's lit phase
        for (int i = 0; i < 20; i++) tick();
        chk("pre_rst_en", {28'd0, digito_en}, 32'h0000000B);
        chk("pre_rst_seg", {25'd0, segmentos}, {25'd0, S2});
        chk("pre_rst_upd", {31'd0, atualizado}, 32'd0);
        reset = 1'b1;
        tick();
        chk("mid_rst_en", {28'd0, digito_en}, 32'h0000000F);
        chk("mid_rst_seg", {25'd0, segmentos}, {25'd0, SB});
        chk("mid_rst_state", {31'd0, o_estado}, 32'd0);
        reset = 1'b0;
        apagar_zeros = 1'b0;

        // Back to digit 0 first, showing zeros; shadow was cleared too
        check_frame("post_rst0", {S0, S0, S0, S0}, 1'b0, -1, 16'h0, -1, 16'h0);
        check_frame("post_rst1", {S0, S0, S0, S0}, 1'b0, -1, 16'h0, -1, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
